// File: rtl/systolic_operand_feeder.sv
// Operand feeder / result sink for a 2x2 systolic array; optional DRAIN watchdog under SYSTOLIC_FEEDER_TIMEOUT_EN.
// Latency: arr_in_valid rises the cycle after the 8th accepted element; r_valid the cycle after arr_out_valid in DRAIN.
// Backpressure: s_ready only in LOAD; the result is held indefinitely while r_ready is low.
module systolic_operand_feeder #(
  parameter int DATA_WIDTH  = 4,
  parameter int ACC_WIDTH   = 9,
  parameter int FEED_CYCLES = 4,
  parameter int DRAIN_TMO   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   arr_in_valid,
  output logic [DATA_WIDTH-1:0]  arr_a00,
  output logic [DATA_WIDTH-1:0]  arr_a01,
  output logic [DATA_WIDTH-1:0]  arr_a10,
  output logic [DATA_WIDTH-1:0]  arr_a11,
  output logic [DATA_WIDTH-1:0]  arr_b00,
  output logic [DATA_WIDTH-1:0]  arr_b01,
  output logic [DATA_WIDTH-1:0]  arr_b10,
  output logic [DATA_WIDTH-1:0]  arr_b11,
  input  logic                   arr_out_valid,
  input  logic [ACC_WIDTH-1:0]   arr_c00,
  input  logic [ACC_WIDTH-1:0]   arr_c01,
  input  logic [ACC_WIDTH-1:0]   arr_c10,
  input  logic [ACC_WIDTH-1:0]   arr_c11,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [4*ACC_WIDTH-1:0] r_data,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int FW = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES + 1) : 1;

  if (FEED_CYCLES < 1 || DRAIN_TMO < 1) begin : g_bad_cfg
    $error("systolic_operand_feeder: FEED_CYCLES and DRAIN_TMO must be >= 1");
  end

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FEED   = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q;
  logic [DATA_WIDTH-1:0]  op_q [8];
  logic [FW-1:0]          feed_cnt_q;
  logic [4*ACC_WIDTH-1:0] r_data_q;
  logic                   accept;
  logic                   feed_done;
  logic                   capture;
  logic                   tmo_hit;

  assign accept    = s_valid && s_ready;
  assign feed_done = (feed_cnt_q == FW'(FEED_CYCLES - 1));
  assign capture   = (state_q == DRAIN) && arr_out_valid;

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TMO + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_err_q;

  // A result arriving in the last allowed DRAIN cycle takes priority over the abort.
  assign tmo_hit = (state_q == DRAIN) && !arr_out_valid && (tmo_cnt_q == TW'(DRAIN_TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == DRAIN) ? tmo_cnt_q + 1'b1 : '0;
      if (tmo_hit)
        timeout_err_q <= 1'b1;
      else if (accept)
        timeout_err_q <= 1'b0;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= LOAD;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && cnt_q == 3'd7) state_d = FEED;
      FEED:    if (feed_done)               state_d = DRAIN;
      DRAIN: begin
        if (arr_out_valid)
          state_d = RESULT;
        else if (tmo_hit)
          state_d = LOAD;
      end
      RESULT:  if (r_ready)                 state_d = LOAD;
      default:                              state_d = LOAD;
    endcase
  end

  // The 3-bit element count wraps to 0 on the 8th accept, ready for the next job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      feed_cnt_q <= '0;
      r_data_q   <= '0;
      for (int i = 0; i < 8; i++) op_q[i] <= '0;
    end else begin
      if (accept) begin
        op_q[cnt_q] <= s_data;
        cnt_q       <= cnt_q + 3'd1;
      end
      feed_cnt_q <= (state_q == FEED && !feed_done) ? feed_cnt_q + 1'b1 : '0;
      if (capture)
        r_data_q <= {arr_c11, arr_c10, arr_c01, arr_c00};
    end
  end

  logic a_en, b_en;
  assign a_en = (state_q == FEED);
  assign b_en = (state_q == FEED) || (state_q == DRAIN);

  // Gate with rst so every output reads 0 while reset is held.
  assign s_ready      = (state_q == LOAD) && !rst;
  assign arr_in_valid = b_en;
  assign arr_a00      = a_en ? op_q[0] : '0;
  assign arr_a01      = a_en ? op_q[1] : '0;
  assign arr_a10      = a_en ? op_q[2] : '0;
  assign arr_a11      = a_en ? op_q[3] : '0;
  assign arr_b00      = b_en ? op_q[4] : '0;
  assign arr_b01      = b_en ? op_q[5] : '0;
  assign arr_b10      = b_en ? op_q[6] : '0;
  assign arr_b11      = b_en ? op_q[7] : '0;
  assign r_valid      = (state_q == RESULT);
  assign r_data       = r_data_q;
  assign busy         = !((state_q == LOAD) && (cnt_q == 3'd0));

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder with a stub array answering on arr_out_valid.
module tb_systolic_operand_feeder;

  logic        clk, rst;
  logic        s_valid, s_ready;
  logic [3:0]  s_data;
  logic        arr_in_valid;
  logic [3:0]  arr_a00, arr_a01, arr_a10, arr_a11;
  logic [3:0]  arr_b00, arr_b01, arr_b10, arr_b11;
  logic        arr_out_valid;
  logic [8:0]  arr_c00, arr_c01, arr_c10, arr_c11;
  logic        r_valid, r_ready;
  logic [35:0] r_data;
  logic        busy, timeout_err;
  logic [31:0] ops;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] OPS1   = 32'h1234_5678;
  localparam logic [31:0] OPS1_D = 32'h0000_5678;
  localparam logic [31:0] OPS4   = 32'h0110_2345;
  localparam logic [35:0] RES1   = {9'd50, 9'd43, 9'd22, 9'd19};
  localparam logic [35:0] RES4   = {9'd3, 9'd2, 9'd5, 9'd4};

  systolic_operand_feeder dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .arr_in_valid(arr_in_valid),
    .arr_a00(arr_a00), .arr_a01(arr_a01), .arr_a10(arr_a10), .arr_a11(arr_a11),
    .arr_b00(arr_b00), .arr_b01(arr_b01), .arr_b10(arr_b10), .arr_b11(arr_b11),
    .arr_out_valid(arr_out_valid),
    .arr_c00(arr_c00), .arr_c01(arr_c01), .arr_c10(arr_c10), .arr_c11(arr_c11),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  assign ops = {arr_a00, arr_a01, arr_a10, arr_a11, arr_b00, arr_b01, arr_b10, arr_b11};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends a00..b11 (a00 in the top nibble), back-to-back; ends one step after the 8th accept.
  task automatic load(input logic [31:0] e);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = e[31-4*i -: 4];
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // Called in DRAIN cycle 1; answers in DRAIN cycle n.
  task automatic stub_return(input int n, input logic [8:0] c00, c01, c10, c11);
    repeat (n - 1) tick();
    arr_out_valid = 1'b1;
    arr_c00 = c00; arr_c01 = c01; arr_c10 = c10; arr_c11 = c11;
    tick();
    arr_out_valid = 1'b0;
    arr_c00 = '0; arr_c01 = '0; arr_c10 = '0; arr_c11 = '0;
  endtask

  task automatic take_result();
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (arr_in_valid !== 1'b0 || ops !== 32'h0) begin n_bad++; $display("FAIL reset_arr: got v=%b ops=%h want 0/0", arr_in_valid, ops); end
    n_cmp++; if (r_valid !== 1'b0 || r_data !== 36'h0) begin n_bad++; $display("FAIL reset_result: got v=%b d=%h want 0/0", r_valid, r_data); end
    n_cmp++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got busy=%b terr=%b want 0/0", busy, timeout_err); end
    rst = 1'b0;
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL idle_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_basic();
    load(OPS1);
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (arr_in_valid !== 1'b1 || ops !== OPS1 || s_ready !== 1'b0) begin
        n_bad++; $display("FAIL basic_feed[%0d]: got v=%b ops=%h rdy=%b want 1/%h/0", c, arr_in_valid, ops, s_ready, OPS1);
      end
      tick();
    end
    n_cmp++; if (arr_in_valid !== 1'b1 || ops !== OPS1_D) begin n_bad++; $display("FAIL basic_drain: got v=%b ops=%h want 1/%h", arr_in_valid, ops, OPS1_D); end
    stub_return(6, 9'd19, 9'd22, 9'd43, 9'd50);
    n_cmp++; if (r_valid !== 1'b1 || r_data !== RES1) begin n_bad++; $display("FAIL basic_result: got v=%b d=%h want 1/%h", r_valid, r_data, RES1); end
    n_cmp++; if (arr_in_valid !== 1'b0) begin n_bad++; $display("FAIL basic_invalid_drop: got %b want 0", arr_in_valid); end
    take_result();
    n_cmp++; if (r_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_back_to_load: got v=%b rdy=%b busy=%b want 0/1/0", r_valid, s_ready, busy); end
  endtask

  task automatic test_gaps();
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        n_cmp++; if (arr_in_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL gaps_pre_last: got v=%b busy=%b want 0/1", arr_in_valid, busy); end
      end
      s_valid = 1'b1;
      s_data  = OPS1[31-4*i -: 4];
      if (s_valid && s_ready) acc++;
      tick();
      s_valid = 1'b0;
      if (i < 7) begin
        repeat (2) begin
          if (s_valid && s_ready) acc++;
          tick();
        end
      end
    end
    n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL gaps_accepts: got %0d want 8", acc); end
    n_cmp++; if (arr_in_valid !== 1'b1 || ops !== OPS1) begin n_bad++; $display("FAIL gaps_feed_start: got v=%b ops=%h want 1/%h", arr_in_valid, ops, OPS1); end
    repeat (4) tick();
    stub_return(6, 9'd19, 9'd22, 9'd43, 9'd50);
    n_cmp++; if (r_valid !== 1'b1 || r_data !== RES1) begin n_bad++; $display("FAIL gaps_result: got v=%b d=%h want 1/%h", r_valid, r_data, RES1); end
    take_result();
  endtask

  task automatic test_hold_result();
    load(OPS1);
    repeat (4) tick();
    stub_return(3, 9'd19, 9'd22, 9'd43, 9'd50);
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (r_valid !== 1'b1 || r_data !== RES1 || s_ready !== 1'b0) begin
        n_bad++; $display("FAIL hold[%0d]: got v=%b d=%h rdy=%b want 1/%h/0", c, r_valid, r_data, s_ready, RES1);
      end
      tick();
    end
    take_result();
    n_cmp++; if (r_valid !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release: got v=%b rdy=%b want 0/1", r_valid, s_ready); end
  endtask

  task automatic test_mid_reset();
    load(OPS1);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (arr_in_valid !== 1'b0 || ops !== 32'h0 || s_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_arr: got v=%b ops=%h rdy=%b want 0/0/0", arr_in_valid, ops, s_ready); end
    n_cmp++; if (r_valid !== 1'b0 || r_data !== 36'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_result: got v=%b d=%h busy=%b want 0/0/0", r_valid, r_data, busy); end
    tick();
    rst = 1'b0;
    load(OPS4);
    n_cmp++; if (arr_in_valid !== 1'b1 || ops !== OPS4) begin n_bad++; $display("FAIL midrst_feed: got v=%b ops=%h want 1/%h", arr_in_valid, ops, OPS4); end
    repeat (4) tick();
    stub_return(2, 9'd4, 9'd5, 9'd2, 9'd3);
    n_cmp++; if (r_valid !== 1'b1 || r_data !== RES4) begin n_bad++; $display("FAIL midrst_result2: got v=%b d=%h want 1/%h", r_valid, r_data, RES4); end
    take_result();
  endtask

  task automatic test_spurious_out_valid();
    arr_out_valid = 1'b1;
    arr_c00 = 9'd7; arr_c01 = 9'd7; arr_c10 = 9'd7; arr_c11 = 9'd7;
    load(OPS1);
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (r_valid !== 1'b0 || arr_in_valid !== 1'b1) begin n_bad++; $display("FAIL spur_feed[%0d]: got rv=%b iv=%b want 0/1", c, r_valid, arr_in_valid); end
      tick();
    end
    arr_out_valid = 1'b0;
    arr_c00 = '0; arr_c01 = '0; arr_c10 = '0; arr_c11 = '0;
    n_cmp++; if (r_valid !== 1'b0 || ops !== OPS1_D || r_data !== RES4) begin n_bad++; $display("FAIL spur_drain: got rv=%b ops=%h d=%h want 0/%h/%h", r_valid, ops, r_data, OPS1_D, RES4); end
    stub_return(4, 9'd19, 9'd22, 9'd43, 9'd50);
    n_cmp++; if (r_valid !== 1'b1 || r_data !== RES1) begin n_bad++; $display("FAIL spur_result: got v=%b d=%h want 1/%h", r_valid, r_data, RES1); end
    take_result();
  endtask

  task automatic test_drain_wait();
    load(OPS1);
    repeat (4) tick();
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    repeat (15) tick();
    n_cmp++; if (arr_in_valid !== 1'b1 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_cycle16: got iv=%b terr=%b want 1/0", arr_in_valid, timeout_err); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1 || arr_in_valid !== 1'b0 || s_ready !== 1'b1 || r_valid !== 1'b0) begin
      n_bad++; $display("FAIL tmo_abort: got terr=%b iv=%b rdy=%b rv=%b want 1/0/1/0", timeout_err, arr_in_valid, s_ready, r_valid);
    end
    s_valid = 1'b1;
    s_data  = 4'h1;
    tick();
    s_valid = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_clear: got terr=%b busy=%b want 0/1", timeout_err, busy); end
`else
    repeat (100) tick();
    n_cmp++; if (arr_in_valid !== 1'b1 || ops !== OPS1_D || timeout_err !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++; $display("FAIL drain_wait: got iv=%b ops=%h terr=%b rdy=%b want 1/%h/0/0", arr_in_valid, ops, timeout_err, s_ready, OPS1_D);
    end
    stub_return(1, 9'd19, 9'd22, 9'd43, 9'd50);
    n_cmp++; if (r_valid !== 1'b1 || r_data !== RES1) begin n_bad++; $display("FAIL drain_wait_result: got v=%b d=%h want 1/%h", r_valid, r_data, RES1); end
    take_result();
`endif
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
    arr_out_valid = 1'b0;
    arr_c00 = '0; arr_c01 = '0; arr_c10 = '0; arr_c11 = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_hold_result();
    test_mid_reset();
    test_spurious_out_valid();
    test_drain_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
